// File: rtl/twiddle_cmul_if.sv
// Handshake and data bundle for the twiddle complex multiplier.
// The slave modport is the multiplier's view; the master modport is the driver's view.
interface twiddle_cmul_if #(parameter int N = 16);
  logic signed [N-1:0] i_tw_re0, i_tw_re1, i_tw_re2, i_tw_re3;
  logic signed [N-1:0] i_tw_re4, i_tw_re5, i_tw_re6, i_tw_re7;
  logic signed [N-1:0] i_tw_im0, i_tw_im1, i_tw_im2, i_tw_im3;
  logic signed [N-1:0] i_tw_im4, i_tw_im5, i_tw_im6, i_tw_im7;
  logic                i_valid, o_ready;
  logic signed [N-1:0] i_re, i_im;
  logic [2:0]          i_k;
  logic                i_conj;
  logic                o_valid, i_ready;
  logic signed [N-1:0] o_re, o_im;
  logic [2:0]          o_k;
  logic                o_sat;

  modport slave (
    input  i_tw_re0, i_tw_re1, i_tw_re2, i_tw_re3, i_tw_re4, i_tw_re5, i_tw_re6, i_tw_re7,
    input  i_tw_im0, i_tw_im1, i_tw_im2, i_tw_im3, i_tw_im4, i_tw_im5, i_tw_im6, i_tw_im7,
    input  i_valid, i_re, i_im, i_k, i_conj, i_ready,
    output o_ready, o_valid, o_re, o_im, o_k, o_sat
  );
  modport master (
    output i_tw_re0, i_tw_re1, i_tw_re2, i_tw_re3, i_tw_re4, i_tw_re5, i_tw_re6, i_tw_re7,
    output i_tw_im0, i_tw_im1, i_tw_im2, i_tw_im3, i_tw_im4, i_tw_im5, i_tw_im6, i_tw_im7,
    output i_valid, i_re, i_im, i_k, i_conj, i_ready,
    input  o_ready, o_valid, o_re, o_im, o_k, o_sat
  );
endinterface

// File: rtl/twiddle_cmul.sv
// Three-stage Q8.8 complex multiply by a selected twiddle (optionally conjugated),
// round-half-up and saturate, with a single global stall enable.
module twiddle_cmul #(parameter int N = 16) (
  input logic           i_clk,
  input logic           i_rst,
  twiddle_cmul_if.slave bus
);
  localparam int STAGES = 3;
  localparam int FRAC   = 8;
  localparam logic signed [2*N:0] RND  = (2*N+1)'(1) <<< (FRAC-1);
  localparam logic signed [2*N:0] MAXV = ((2*N+1)'(1) <<< (N-1)) - (2*N+1)'(1);
  localparam logic signed [2*N:0] MINV = -MAXV - (2*N+1)'(1);

  typedef struct packed {
    logic [N-1:0] ar, ai, wr, wi;
    logic         conj;
    logic [2:0]   k;
  } s1_t;

  typedef struct packed {
    logic [2*N-1:0] pr, pi, pa, pb;
    logic           conj;
    logic [2:0]     k;
  } s2_t;

  logic [STAGES:1]     vld_q;
  logic [STAGES:0]     vld_pipe;
  logic                adv;
  logic signed [N-1:0] tw_re, tw_im;
  s1_t                 s1;
  s2_t                 s2;
  logic signed [2*N:0] sum_re, sum_im;
  logic [N:0]          res_re, res_im;
  logic signed [N-1:0] re_q, im_q;
  logic [2:0]          k_q;
  logic                sat_q;

  assign vld_pipe    = {vld_q, bus.i_valid};
  assign adv         = !vld_q[STAGES] | bus.i_ready;
  assign bus.o_ready = adv;
  assign bus.o_valid = vld_q[STAGES];
  assign bus.o_re    = re_q;
  assign bus.o_im    = im_q;
  assign bus.o_k     = k_q;
  assign bus.o_sat   = sat_q;

  always_comb begin
    tw_re = bus.i_tw_re0;
    tw_im = bus.i_tw_im0;
    case (bus.i_k)
      3'd1: begin tw_re = bus.i_tw_re1; tw_im = bus.i_tw_im1; end
      3'd2: begin tw_re = bus.i_tw_re2; tw_im = bus.i_tw_im2; end
      3'd3: begin tw_re = bus.i_tw_re3; tw_im = bus.i_tw_im3; end
      3'd4: begin tw_re = bus.i_tw_re4; tw_im = bus.i_tw_im4; end
      3'd5: begin tw_re = bus.i_tw_re5; tw_im = bus.i_tw_im5; end
      3'd6: begin tw_re = bus.i_tw_re6; tw_im = bus.i_tw_im6; end
      3'd7: begin tw_re = bus.i_tw_re7; tw_im = bus.i_tw_im7; end
      default: ;
    endcase
  end

  // Returns {clamped, value}: round half toward +inf, then clamp to signed N bits.
  function automatic logic [N:0] rnd_sat(input logic signed [2*N:0] s);
    logic signed [2*N:0] r;
    r = (s + RND) >>> FRAC;
    if (r > MAXV)      return {1'b1, MAXV[N-1:0]};
    else if (r < MINV) return {1'b1, MINV[N-1:0]};
    else               return {1'b0, r[N-1:0]};
  endfunction

  always_comb begin
    if (s2.conj) begin
      sum_re = (2*N+1)'($signed(s2.pr)) + (2*N+1)'($signed(s2.pi));
      sum_im = (2*N+1)'($signed(s2.pa)) - (2*N+1)'($signed(s2.pb));
    end else begin
      sum_re = (2*N+1)'($signed(s2.pr)) - (2*N+1)'($signed(s2.pi));
      sum_im = (2*N+1)'($signed(s2.pa)) + (2*N+1)'($signed(s2.pb));
    end
    res_re = rnd_sat(sum_re);
    res_im = rnd_sat(sum_im);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q <= '0;
      s1    <= '0;
      s2    <= '0;
      re_q  <= '0;
      im_q  <= '0;
      k_q   <= '0;
      sat_q <= 1'b0;
    end else if (adv) begin
      vld_q   <= vld_pipe[STAGES-1:0];
      s1.ar   <= bus.i_re;
      s1.ai   <= bus.i_im;
      s1.wr   <= tw_re;
      s1.wi   <= tw_im;
      s1.conj <= bus.i_conj;
      s1.k    <= bus.i_k;
      s2.pr   <= (2*N)'($signed(s1.ar)) * (2*N)'($signed(s1.wr));
      s2.pi   <= (2*N)'($signed(s1.ai)) * (2*N)'($signed(s1.wi));
      s2.pa   <= (2*N)'($signed(s1.ai)) * (2*N)'($signed(s1.wr));
      s2.pb   <= (2*N)'($signed(s1.ar)) * (2*N)'($signed(s1.wi));
      s2.conj <= s1.conj;
      s2.k    <= s1.k;
      re_q    <= res_re[N-1:0];
      im_q    <= res_im[N-1:0];
      k_q     <= s2.k;
      // Bubbles in S2 must not raise the sticky flag.
      if (vld_pipe[2] && (res_re[N] || res_im[N])) sat_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_twiddle_cmul.sv
// Randomized and directed bench for twiddle_cmul against a plain-arithmetic complex
// multiply model with an in-order expected-result queue.
module tb_twiddle_cmul;
  localparam int N    = 16;
  localparam int MAXI = (1 <<< (N-1)) - 1;
  localparam int MINI = -(1 <<< (N-1));

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  twiddle_cmul_if #(.N(N)) bus();
  twiddle_cmul #(.N(N)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  logic signed [N-1:0] twr [8];
  logic signed [N-1:0] twi [8];
  assign bus.i_tw_re0 = twr[0]; assign bus.i_tw_im0 = twi[0];
  assign bus.i_tw_re1 = twr[1]; assign bus.i_tw_im1 = twi[1];
  assign bus.i_tw_re2 = twr[2]; assign bus.i_tw_im2 = twi[2];
  assign bus.i_tw_re3 = twr[3]; assign bus.i_tw_im3 = twi[3];
  assign bus.i_tw_re4 = twr[4]; assign bus.i_tw_im4 = twi[4];
  assign bus.i_tw_re5 = twr[5]; assign bus.i_tw_im5 = twi[5];
  assign bus.i_tw_re6 = twr[6]; assign bus.i_tw_im6 = twi[6];
  assign bus.i_tw_re7 = twr[7]; assign bus.i_tw_im7 = twi[7];

  typedef struct { int re; int im; int k; bit sat; int acc; } exp_t;
  exp_t q[$];
  int   total = 0, bad = 0;
  int   cnum  = 0;
  bit   msat  = 1'b0;
  bit   lat_on = 1'b0;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int rc(input longint s, inout bit sat);
    longint r;
    r = (s + 128) >>> 8;
    if (r > MAXI) begin sat = 1'b1; return MAXI; end
    if (r < MINI) begin sat = 1'b1; return MINI; end
    return int'(r);
  endfunction

  // (ar + j*ai) * (wr +/- j*wi)
  function automatic exp_t model(input int ar, input int ai, input int wr, input int wi,
                                 input bit cj, input int k);
    exp_t   e;
    longint sr, si, pwi;
    pwi  = cj ? -longint'(wi) : longint'(wi);
    sr   = longint'(ar) * wr - longint'(ai) * pwi;
    si   = longint'(ai) * wr + longint'(ar) * pwi;
    e.sat = 1'b0;
    e.re  = rc(sr, e.sat);
    e.im  = rc(si, e.sat);
    e.k   = k;
    e.acc = 0;
    return e;
  endfunction

  task automatic cyc(input bit v, input int re, input int im, input int k, input bit cj,
                     input bit rdy, input bit rtw, output bit took);
    exp_t e;
    @(negedge i_clk);
    if (rtw)
      for (int i = 0; i < 8; i++) begin
        twr[i] = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, 512) - 256);
        twi[i] = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, 512) - 256);
      end
    bus.i_valid = v;
    bus.i_re    = N'(re);
    bus.i_im    = N'(im);
    bus.i_k     = 3'(k);
    bus.i_conj  = cj;
    bus.i_ready = rdy;
    #1;
    cnum++;
    if (bus.o_valid && bus.i_ready) begin
      chk("out_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        msat |= e.sat;
        chk("o_re", bus.o_re, e.re);
        chk("o_im", bus.o_im, e.im);
        chk("o_k", bus.o_k, e.k);
        chk("o_sat", bus.o_sat, msat);
        if (lat_on) chk("latency", cnum - e.acc, 3);
      end
    end
    took = bus.i_valid && bus.o_ready;
    if (took) begin
      e = model(int'(bus.i_re), int'(bus.i_im), int'(twr[bus.i_k]), int'(twi[bus.i_k]),
                bus.i_conj, int'(bus.i_k));
      e.acc = cnum;
      q.push_back(e);
    end
  endtask

  task automatic send(input int re, input int im, input int k, input bit cj);
    bit t;
    cyc(1'b1, re, im, k, cj, 1'b1, 1'b0, t);
    chk("accepted", t, 1);
  endtask

  task automatic idle(input int n);
    bit t;
    repeat (n) cyc(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, t);
  endtask

  initial begin
    bit t;
    bit     snap_v;
    longint snap_re, snap_im, snap_k;
    int     sent;
    int     bre [6];
    int     bim [6];
    twr[0] = 256;  twi[0] = 0;
    twr[1] = 236;  twi[1] = 98;
    twr[2] = 181;  twi[2] = 181;
    twr[3] = 98;   twi[3] = 236;
    twr[4] = 0;    twi[4] = 256;
    twr[5] = -98;  twi[5] = 236;
    twr[6] = -181; twi[6] = 181;
    twr[7] = -236; twi[7] = 98;
    bus.i_valid = 1'b0; bus.i_re = '0; bus.i_im = '0; bus.i_k = '0;
    bus.i_conj = 1'b0; bus.i_ready = 1'b1;

    repeat (2) @(negedge i_clk);
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_ready", bus.o_ready, 1);
    chk("rst_o_sat", bus.o_sat, 0);
    chk("rst_o_re", bus.o_re, 0);
    chk("rst_o_im", bus.o_im, 0);
    chk("rst_o_k", bus.o_k, 0);
    i_rst = 1'b0;

    // Identity, quarter turns, rounding, then eight back-to-back indices
    lat_on = 1'b1;
    send(1000, -500, 0, 1'b0);
    idle(4);
    send(100, 200, 4, 1'b0);
    send(100, 200, 4, 1'b1);
    send(256, 0, 2, 1'b0);
    for (int k = 0; k < 8; k++) send($urandom_range(0, 4000) - 2000, $urandom_range(0, 4000) - 2000, k, k[0]);
    idle(4);

    // Saturation is sticky across later clean results
    send(32767, 32767, 2, 1'b0);
    send(300, -300, 1, 1'b0);
    send(-5, 7, 6, 1'b1);
    idle(4);
    chk("sat_sticky", bus.o_sat, 1);

    // Backpressure: stall downstream for 5 cycles mid-stream
    lat_on = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bre[i] = $urandom_range(0, 20000) - 10000;
      bim[i] = $urandom_range(0, 20000) - 10000;
    end
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(sent < 6, (sent < 6) ? bre[sent] : 0, (sent < 6) ? bim[sent] : 0, sent % 8, 1'b0,
          !(c >= 4 && c < 9), 1'b0, t);
      if (t) sent++;
      if (c == 4) begin
        snap_v = bus.o_valid; snap_re = bus.o_re; snap_im = bus.o_im; snap_k = bus.o_k;
        chk("stall_o_valid", snap_v, 1);
      end
      if (c >= 4 && c < 9) chk("stall_o_ready", bus.o_ready, 0);
      if (c > 4 && c <= 9) begin
        chk("stall_hold_valid", bus.o_valid, snap_v);
        chk("stall_hold_re", bus.o_re, snap_re);
        chk("stall_hold_im", bus.o_im, snap_im);
        chk("stall_hold_k", bus.o_k, snap_k);
      end
    end
    chk("bp_sent", sent, 6);
    chk("bp_drained", q.size(), 0);

    // Reset with two samples in flight
    lat_on = 1'b1;
    send(1234, 567, 3, 1'b0);
    send(-800, 90, 5, 1'b1);
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("midrst_o_valid", bus.o_valid, 0);
    chk("midrst_o_sat", bus.o_sat, 0);
    chk("midrst_o_ready", bus.o_ready, 1);
    q.delete();
    msat = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk("midrst_no_out", bus.o_valid, 0);
    end

    // Random traffic with twiddles changing every cycle and random backpressure
    lat_on = 1'b0;
    for (int i = 0; i < 400; i++) begin
      int re, im;
      re = ($urandom_range(0, 3) == 0) ? int'($urandom) : $urandom_range(0, 4000) - 2000;
      im = ($urandom_range(0, 3) == 0) ? int'($urandom) : $urandom_range(0, 4000) - 2000;
      cyc($urandom_range(0, 3) != 0, re, im, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0, 1'b1, t);
    end
    idle(8);
    chk("final_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
